// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_pkg
//  Description : Shared definitions for the convolution tap sequencer:
//                default widths, sequencer state encoding, and the 8-bit
//                pixel clamp applied to the signed accumulated sum.
//  Revision    : 1.0  initial release
// ============================================================================
package conv_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Saturate a signed sum into the displayable 0..255 pixel range.
    // Callers sign-extend their accumulator to 64 bits first.
    function automatic logic [7:0] clamp_u8(input logic signed [63:0] v);
        if (v < 64'sd0)
            return 8'd0;
        else if (v > 64'sd255)
            return 8'hFF;
        else
            return v[7:0];
    endfunction

endpackage : conv_pkg
`default_nettype wire

// File: rtl/conv_coef_bank.sv
`default_nettype none
// ============================================================================
//  Module      : conv_coef_bank
//  Description : TAPS-entry kernel weight register file. One write port
//                (qualified by the caller), one combinational read port.
//  Ports       : Clk, Reset (async, active-high) ; we/waddr/wdata write ;
//                raddr -> rdata combinational read.
//  Revision    : 1.0  initial release
// ============================================================================
module conv_coef_bank #(
    parameter int TAPS   = 9,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    // All taps flattened so the read mux is a single indexed part-select.
    logic [TAPS*DATA_W-1:0] taps_flat;

    for (genvar i = 0; i < TAPS; i++) begin : g_tap
        logic [DATA_W-1:0] tap_q;
        logic [DATA_W-1:0] tap_d;

        always_comb begin
            tap_d = tap_q;
            if (we && (waddr == ADDR_W'(i)))
                tap_d = wdata;
        end

        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset)
                tap_q <= '0;
            else
                tap_q <= tap_d;
        end

        assign taps_flat[i*DATA_W +: DATA_W] = tap_q;
    end

    assign rdata = taps_flat[int'(raddr)*DATA_W +: DATA_W];

endmodule : conv_coef_bank
`default_nettype wire

// File: rtl/conv_tap_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : conv_tap_sequencer
//  Description : Feeds (pixel, weight) pairs to an external MAC for each
//                accepted image window, waits for the MAC pipeline to settle,
//                captures the accumulated sum and presents it (plus an
//                8-bit clamped pixel) on a valid/ready output.
//  Ports       : Clk, Reset (async, active-high)
//                coef_we/coef_addr/coef_data : kernel write (IDLE only)
//                win_valid/win_ready/win_data: window input handshake
//                x, y, AccumReset            : MAC operands and clear
//                LocalReg                    : MAC accumulator value
//                out_valid/out_ready/out_data/out_pix : result handshake
//                busy                        : high outside IDLE
//  Revision    : 1.0  initial release
// ============================================================================
module conv_tap_sequencer
    import conv_pkg::*;
#(
    parameter int TAPS    = 9,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int MAC_LAT = 1,
    localparam int ADDR_W = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   coef_we,
    input  logic [ADDR_W-1:0]      coef_addr,
    input  logic [DATA_W-1:0]      coef_data,
    input  logic                   win_valid,
    output logic                   win_ready,
    input  logic [TAPS*DATA_W-1:0] win_data,
    output logic [DATA_W-1:0]      x,
    output logic [DATA_W-1:0]      y,
    output logic                   AccumReset,
    input  logic [ACC_W-1:0]       LocalReg,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_W-1:0]       out_data,
    output logic [7:0]             out_pix,
    output logic                   busy
);

    localparam logic [ADDR_W-1:0] IDX_LAST   = ADDR_W'(TAPS - 1);
    localparam logic [2:0]        DRAIN_LAST = 3'(MAC_LAT - 1);

    state_t                  state_q,  state_d;
    logic [ADDR_W-1:0]       idx_q,    idx_d;
    logic [2:0]              drain_q,  drain_d;
    logic [TAPS*DATA_W-1:0]  win_q,    win_d;
    logic [ACC_W-1:0]        result_q, result_d;

    logic                    coef_wr_en;
    logic [DATA_W-1:0]       coef_rd;

    // Kernel may only change between windows so a window in flight always
    // sees one consistent kernel. Same-cycle write + accept is fine: the
    // first tap is read two edges later.
    assign coef_wr_en = coef_we && (state_q == IDLE) &&
                        ({{(32-ADDR_W){1'b0}}, coef_addr} < 32'(TAPS));

    conv_coef_bank #(
        .TAPS   (TAPS),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_coef_bank (
        .Clk   (Clk),
        .Reset (Reset),
        .we    (coef_wr_en),
        .waddr (coef_addr),
        .wdata (coef_data),
        .raddr (idx_q),
        .rdata (coef_rd)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        drain_d  = drain_q;
        win_d    = win_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    win_d   = win_data;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                idx_d   = '0;
                state_d = STREAM;
            end
            STREAM: begin
                if (idx_q == IDX_LAST) begin
                    drain_d = '0;
                    state_d = DRAIN;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DRAIN: begin
                // Zero operands keep the sum while the MAC pipeline empties.
                if (drain_q == DRAIN_LAST) begin
                    result_d = LocalReg;
                    state_d  = DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            drain_q  <= '0;
            win_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            drain_q  <= drain_d;
            win_q    <= win_d;
            result_q <= result_d;
        end
    end

    // Reset is folded into the outputs so the MAC is held clear and no
    // window is accepted while Reset is asserted.
    assign win_ready  = (state_q == IDLE) && !Reset;
    assign AccumReset = Reset || (state_q == CLEAR);
    assign x          = (state_q == STREAM) ? win_q[int'(idx_q)*DATA_W +: DATA_W] : '0;
    assign y          = (state_q == STREAM) ? coef_rd : '0;
    assign out_valid  = (state_q == DONE);
    assign out_data   = result_q;
    assign out_pix    = clamp_u8(64'($signed(result_q)));
    assign busy       = (state_q != IDLE);

endmodule : conv_tap_sequencer
`default_nettype wire

// File: tb/tb_conv_tap_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_tap_sequencer
//  Description : Directed self-checking bench for conv_tap_sequencer with a
//                behavioural MAC closing the x/y -> LocalReg loop.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_conv_tap_sequencer;

    localparam int TAPS = 9;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        coef_we = 1'b0;
    logic [3:0]  coef_addr = '0;
    logic [7:0]  coef_data = '0;
    logic        win_valid = 1'b0;
    logic        win_ready;
    logic [71:0] win_data = '0;
    logic [7:0]  x, y;
    logic        AccumReset;
    logic [31:0] LocalReg = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [7:0]  out_pix;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    conv_tap_sequencer #(.TAPS(9), .DATA_W(8), .ACC_W(32), .MAC_LAT(1)) dut (
        .Clk(Clk), .Reset(Reset),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
        .x(x), .y(y), .AccumReset(AccumReset), .LocalReg(LocalReg),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_pix(out_pix), .busy(busy)
    );

    // Behavioural MAC
    logic signed [15:0] prod;
    assign prod = $signed(x) * $signed(y);
    always @(posedge Clk) begin
        if (AccumReset) LocalReg <= '0;
        else            LocalReg <= LocalReg + 32'(prod);
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic write_kernel(input logic [7:0] v);
        for (int i = 0; i < TAPS; i++) begin
            coef_we = 1'b1; coef_addr = 4'(i); coef_data = v;
            tick();
        end
        coef_we = 1'b0;
    endtask

    function automatic logic [71:0] fill(input logic [7:0] v);
        return {9{v}};
    endfunction

    // Accepts one window and runs until out_valid (bounded). Leaves the DUT
    // in DONE with out_ready low. With stray=1 a tap-0 write of 5 is held
    // on the kernel port for the whole window.
    task automatic do_window(input logic [71:0] win, input bit stray,
                             output int lat, output int ar_first, output int ar_cnt,
                             output int wr_hi, output int first_x);
        out_ready = 1'b0;
        win_data = win; win_valid = 1'b1;
        tick();
        win_valid = 1'b0;
        if (stray) begin coef_we = 1'b1; coef_addr = 4'd0; coef_data = 8'd5; end
        else coef_we = 1'b0;
        lat = 0; ar_first = -1; ar_cnt = 0; wr_hi = 0; first_x = -1;
        while (!out_valid && lat < 40) begin
            if (AccumReset) begin ar_cnt++; if (ar_first < 0) ar_first = lat; end
            if (win_ready) wr_hi++;
            if (lat == 1) first_x = int'(x);
            tick();
            lat++;
        end
        coef_we = 1'b0;
    endtask

    task automatic finish_handshake(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || win_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_return_idle got valid=%b ready=%b want valid=0 ready=1", name, out_valid, win_ready);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (win_ready !== 1'b0 || AccumReset !== 1'b1 || out_valid !== 1'b0 ||
            out_data !== 32'd0 || out_pix !== 8'd0 || busy !== 1'b0 || x !== 8'd0 || y !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b ar=%b v=%b d=%0d p=%0d busy=%b x=%0d y=%0d want 0 1 0 0 0 0 0 0",
                     win_ready, AccumReset, out_valid, out_data, out_pix, busy, x, y);
        end
        tick(); tick();
        @(negedge Clk) Reset = 1'b0;
        #1;
        checks++;
        if (win_ready !== 1'b1 || AccumReset !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got rdy=%b ar=%b want 1 0", win_ready, AccumReset);
        end
    endtask

    task automatic test_ones();
        int lat, arf, arc, wrh, fx;
        logic [71:0] w;
        write_kernel(8'd1);
        for (int i = 0; i < TAPS; i++) w[i*8 +: 8] = 8'(i + 1);
        do_window(w, 1'b0, lat, arf, arc, wrh, fx);
        checks++;
        if (lat !== 11) begin errors++; $display("FAIL ones_latency got %0d want 11", lat); end
        checks++;
        if (out_data !== 32'd45 || out_pix !== 8'd45) begin
            errors++; $display("FAIL ones_sum got %0d/%0d want 45/45", out_data, out_pix);
        end
        checks++;
        if (fx !== 1) begin errors++; $display("FAIL ones_first_x got %0d want 1", fx); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL done_busy got %b want 1", busy); end
        finish_handshake("ones");
    endtask

    task automatic test_neg();
        int lat, arf, arc, wrh, fx;
        write_kernel(8'hFF);
        do_window(fill(8'd10), 1'b0, lat, arf, arc, wrh, fx);
        checks++;
        if (out_data !== 32'hFFFF_FFA6 || out_pix !== 8'd0) begin
            errors++; $display("FAIL neg_sum got %0h/%0d want ffffffa6/0", out_data, out_pix);
        end
        finish_handshake("neg");
    endtask

    task automatic test_sat();
        int lat, arf, arc, wrh, fx;
        write_kernel(8'd127);
        do_window(fill(8'd127), 1'b0, lat, arf, arc, wrh, fx);
        checks++;
        if (out_data !== 32'd145161 || out_pix !== 8'd255) begin
            errors++; $display("FAIL sat_sum got %0d/%0d want 145161/255", out_data, out_pix);
        end
        finish_handshake("sat");
    endtask

    task automatic test_backpressure();
        int lat, arf, arc, wrh, fx;
        int bad = 0;
        write_kernel(8'd2);
        do_window(fill(8'd3), 1'b0, lat, arf, arc, wrh, fx);
        checks++;
        if (arc !== 1 || arf !== 0) begin
            errors++; $display("FAIL accum_reset_pulse got count=%0d at=%0d want 1 at 0", arc, arf);
        end
        checks++;
        if (wrh !== 0) begin errors++; $display("FAIL ready_busy_cycles got %0d want 0", wrh); end
        for (int i = 0; i < 5; i++) begin
            win_valid = 1'b1; win_data = fill(8'd9);
            if (out_valid !== 1'b1 || out_data !== 32'd54 || win_ready !== 1'b0) bad++;
            tick();
        end
        win_valid = 1'b0;
        checks++;
        if (bad !== 0 || out_data !== 32'd54) begin
            errors++; $display("FAIL backpressure_hold got bad=%0d data=%0d want 0/54", bad, out_data);
        end
        finish_handshake("bp");
    endtask

    task automatic test_coef_gating();
        int lat, arf, arc, wrh, fx;
        write_kernel(8'd1);
        do_window(fill(8'd1), 1'b1, lat, arf, arc, wrh, fx);
        checks++;
        if (out_data !== 32'd9) begin errors++; $display("FAIL stream_write_ignored got %0d want 9", out_data); end
        finish_handshake("gate1");
        // IDLE write applies; out-of-range writes are dropped.
        coef_we = 1'b1; coef_addr = 4'd0; coef_data = 8'd5; tick();
        coef_addr = 4'd9;  coef_data = 8'd50; tick();
        coef_addr = 4'd15; coef_data = 8'd50; tick();
        coef_we = 1'b0;
        do_window(fill(8'd1), 1'b0, lat, arf, arc, wrh, fx);
        checks++;
        if (out_data !== 32'd13) begin errors++; $display("FAIL idle_write_applied got %0d want 13", out_data); end
        finish_handshake("gate2");
        // Write in the accept cycle is seen by that window.
        coef_we = 1'b1; coef_addr = 4'd1; coef_data = 8'd3;
        do_window(fill(8'd1), 1'b0, lat, arf, arc, wrh, fx);
        checks++;
        if (out_data !== 32'd15) begin errors++; $display("FAIL same_cycle_write got %0d want 15", out_data); end
        finish_handshake("gate3");
    endtask

    task automatic test_reset_mid_stream();
        int lat, arf, arc, wrh, fx;
        write_kernel(8'd1);
        win_data = fill(8'd5); win_valid = 1'b1;
        tick();
        win_valid = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (x !== 8'd5 || y !== 8'd1) begin errors++; $display("FAIL mid_stream_operands got %0d/%0d want 5/1", x, y); end
        #2 Reset = 1'b1;
        #1;
        checks++;
        if (x !== 8'd0 || y !== 8'd0 || AccumReset !== 1'b1 || out_valid !== 1'b0 ||
            busy !== 1'b0 || win_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs got x=%0d y=%0d ar=%b v=%b busy=%b rdy=%b want 0 0 1 0 0 0",
                     x, y, AccumReset, out_valid, busy, win_ready);
        end
        tick(); tick();
        @(negedge Clk) Reset = 1'b0;
        #1;
        do_window(fill(8'd5), 1'b0, lat, arf, arc, wrh, fx);
        checks++;
        if (lat !== 11 || out_data !== 32'd0 || out_pix !== 8'd0) begin
            errors++; $display("FAIL post_reset_sum got lat=%0d sum=%0d pix=%0d want 11/0/0", lat, out_data, out_pix);
        end
        finish_handshake("post_reset");
    endtask

    initial begin
        test_reset();
        test_ones();
        test_neg();
        test_sat();
        test_backpressure();
        test_coef_gating();
        test_reset_mid_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_conv_tap_sequencer
`default_nettype wire

// File: doc/conv_tap_sequencer.md
Name: conv_tap_sequencer

Overview:
- Upstream feeder for the multiply-accumulate stage of the convolution datapath.
- Holds a TAPS-entry signed kernel and accepts one flattened image window per handshake.
- Per window: pulses AccumReset, streams (pixel, weight) pairs on x/y one per cycle, waits for accumulation to settle, then captures LocalReg.
- Presents the captured sum, plus an 8-bit clamped pixel, on a valid/ready output.

Parameters:
- TAPS, 9, kernel taps per window (3x3); legal range 1..64.
- DATA_W, 8, pixel/weight width; matches the MAC x/y width.
- ACC_W, 32, accumulator/result width; matches LocalReg.
- MAC_LAT, 1, Clk edges from x/y presented to LocalReg reflecting that product; range 1..4.

Ports:
- Clk  in  1  system clock, all logic on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- coef_we  in  1  kernel write strobe.
- coef_addr  in  $clog2(TAPS)  kernel tap index.
- coef_data  in  DATA_W  signed kernel weight.
- win_valid  in  1  window available.
- win_ready  out  1  window accepted when win_valid & win_ready.
- win_data  in  TAPS*DATA_W  unsigned pixels; tap i = bits [i*DATA_W +: DATA_W].
- x  out  DATA_W  pixel to MAC.
- y  out  DATA_W  weight to MAC.
- AccumReset  out  1  MAC accumulator clear.
- LocalReg  in  ACC_W  MAC accumulator value.
- out_valid  out  1  result available.
- out_ready  in  1  result consumed when out_valid & out_ready.
- out_data  out  ACC_W  signed sum of products.
- out_pix  out  8  out_data clamped to 0..255.
- busy  out  1  high in every state except IDLE.

Behaviour:
- MAC contract: each Clk edge, LocalReg <= AccumReset ? 0 : LocalReg + sext(x*y). x and y are treated as signed two's complement by the MAC; pixels are limited to 0..127 so they stay positive.
- Reset (async, any state) forces:
  - state IDLE, tap counter 0, drain counter 0;
  - all kernel weights 0, window register 0, result register 0;
  - win_ready=0 while Reset is asserted, x=y=0, AccumReset=1, out_valid=0, out_data=0, out_pix=0, busy=0.
- States:
  - IDLE: win_ready=1, AccumReset=0, x=y=0. A win handshake loads the window register and moves to CLEAR.
  - CLEAR: one cycle; AccumReset=1, x=y=0. Moves to STREAM with idx=0.
  - STREAM: TAPS cycles; x=win[idx], y=coef[idx], AccumReset=0. idx increments each cycle; after idx=TAPS-1, moves to DRAIN.
  - DRAIN: MAC_LAT cycles; x=y=0 (zero product keeps the sum). On the last DRAIN edge, LocalReg is captured into the result register and the state moves to DONE.
  - DONE: out_valid=1; out_data/out_pix held stable. On out_ready, moves to IDLE; out_valid falls at that edge.
- Latency: out_valid rises 1+TAPS+MAC_LAT edges after the accept edge (11 at defaults). Minimum initiation interval is TAPS+MAC_LAT+3 cycles.
- win_ready is low outside IDLE. A window cannot be accepted in the same cycle as the DONE handshake.
- Kernel writes:
  - taken only in IDLE, and when coef_addr < TAPS;
  - ignored in any other state or for out-of-range addresses;
  - a write and a win handshake in the same IDLE cycle are both honoured; the write is visible to that window.
- out_pix: 0 if out_data < 0; 255 if out_data > 255; otherwise out_data[7:0].
- Reset mid-operation abandons the window with no out_valid pulse. The kernel must be reloaded afterwards.

Decomposition:
- Package conv_pkg:
  - DATA_W/ACC_W defaults;
  - state enum {IDLE, CLEAR, STREAM, DRAIN, DONE};
  - clamp function for out_pix.
- One sub-module, conv_coef_bank: TAPS x DATA_W register file with async-reset write port and combinational read by idx.
- FSM, counters and window register stay in conv_tap_sequencer.

Test Plan:
- All weights 1, window 1..9, behavioural MAC model, out_ready=1 -> out_valid 11 cycles after accept; out_data=45; out_pix=45.
- All weights -1 (0xFF), window all 10 -> out_data=-90; out_pix=0.
- All weights 127, window all 127 -> out_data=145161; out_pix=255.
- out_ready held low 5 cycles in DONE -> out_data stable; win_ready=0 throughout; handshake then returns to IDLE. AccumReset high exactly one cycle before each window's first tap.
- Weight write to tap 0 (value 5) during STREAM -> ignored, sum unchanged. Same write in IDLE -> applied to the next window.
- Reset asserted mid-STREAM -> x=y=0, AccumReset=1, out_valid=0 immediately; after release, kernel reads 0 and the next window sums to 0.
